memory_access: RTL
==================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have ALUout, input, 32 bits: EX-stage result; the byte address for loads and stores, the write-back value otherwise.
REQ-004 SHALL have XM_MD, input, 32 bits: store data.
REQ-005 SHALL have XM_RD, input, 5 bits: destination register.
REQ-006 SHALL have XM_MemtoReg, input, 1 bit: instruction is a load.
REQ-007 SHALL have XM_MemWrite, input, 1 bit: instruction is a store.
REQ-008 SHALL have XM_RegWrite, input, 1 bit: instruction writes the register file.
REQ-009 SHALL have MW_WBData, output, 32 bits: registered write-back value.
REQ-010 SHALL have MW_RD, output, 5 bits: registered destination register.
REQ-011 SHALL have MW_RegWrite, output, 1 bit: registered write enable.
REQ-012 SHALL have MW_Misalign, output, 1 bit: registered flag for a misaligned access in the previous cycle.
REQ-013 SHALL have MW_StoreCnt, output, 16 bits: count of committed stores.

Function
REQ-014 SHALL contain a data memory of 64 words x 32 bits, indexed by ALUout[7:2]; ALUout[31:8] ignored, so addresses wrap modulo 256 bytes.
REQ-015 On each rising edge with XM_MemWrite=1 and ALUout[1:0]=00, SHALL write XM_MD to mem[ALUout[7:2]].
REQ-016 Store with ALUout[1:0]!=00 SHALL be suppressed: memory unchanged, MW_StoreCnt unchanged.
REQ-017 On each rising edge, MW_WBData SHALL load mem[ALUout[7:2]] (memory contents before this edge's write) when XM_MemtoReg=1, else ALUout.
REQ-018 Misaligned load (XM_MemtoReg=1, ALUout[1:0]!=00) SHALL still return the word at ALUout[7:2] and SHALL still honour XM_RegWrite.
REQ-019 MW_Misalign SHALL be set on an edge where (XM_MemWrite or XM_MemtoReg)=1 and ALUout[1:0]!=00, else cleared; it is a one-cycle pulse per offending instruction.
REQ-020 MW_RD SHALL register XM_RD every edge.
REQ-021 MW_RegWrite SHALL register XM_RegWrite AND (XM_RD!=0), so writes to r0 are squashed.
REQ-022 MW_StoreCnt SHALL increment by 1 per committed store and saturate at 16'hFFFF with no wrap.
REQ-023 Latency SHALL be exactly one cycle from inputs to all MW_* outputs; no stall or handshake, one instruction accepted per cycle.
REQ-024 If XM_MemWrite and XM_MemtoReg are both 1, the store SHALL commit and MW_WBData SHALL return the pre-write word.
REQ-025 A load in the cycle after a store to the same word SHALL return the newly stored data.

Reset
REQ-026 While rst=1: MW_WBData=0, MW_RD=0, MW_RegWrite=0, MW_Misalign=0, MW_StoreCnt=0, all 64 memory words=0, asynchronously.
REQ-027 When rst is asserted mid-operation, any store on the same edge SHALL be discarded; normal operation resumes on the first rising edge after rst deasserts.

Verification
REQ-028 Store then load: store ALUout=0x10, XM_MD=0xDEADBEEF; next cycle load 0x10, RD=5, RegWrite=1 -> MW_WBData=0xDEADBEEF, MW_RD=5, MW_RegWrite=1, MW_StoreCnt=1.
REQ-029 Wrap: store 0x12345678 at ALUout=0x104; load ALUout=0x04 -> MW_WBData=0x12345678.
REQ-030 Misaligned store: ALUout=0x21, MemWrite=1, XM_MD=0xFFFFFFFF -> MW_Misalign=1 for one cycle, StoreCnt unchanged; load 0x20 returns 0.
REQ-031 ALU pass-through: ALUout=0x0000ABCD, MemtoReg=0, RD=0, RegWrite=1 -> MW_WBData=0x0000ABCD, MW_RegWrite=0.
REQ-032 Saturation: 65537 aligned stores -> MW_StoreCnt=0xFFFF.
REQ-033 Reset mid-run: after stores, pulse rst between edges -> all outputs 0 immediately; load of any address returns 0.

Source files
------------

// File: rtl/memory_access.sv
// MEM stage of a 5-stage pipeline: 64-word data memory, write-back register
// stage, misalignment flag and a saturating committed-store counter.
module memory_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUout,
  input  logic [31:0] XM_MD,
  input  logic [4:0]  XM_RD,
  input  logic        XM_MemtoReg,
  input  logic        XM_MemWrite,
  input  logic        XM_RegWrite,
  output logic [31:0] MW_WBData,
  output logic [4:0]  MW_RD,
  output logic        MW_RegWrite,
  output logic        MW_Misalign,
  output logic [15:0] MW_StoreCnt
);

  localparam int unsigned DEPTH = 64;

  logic [31:0] mem_reg [DEPTH];
  logic [5:0]  word_idx;
  logic        aligned;
  logic        store_ok;
  logic        misalign_next;
  logic [31:0] wb_next;
  logic [31:0] rd_word;

  assign word_idx      = ALUout[7:2];
  assign aligned       = (ALUout[1:0] == 2'b00);
  assign store_ok      = XM_MemWrite && aligned;
  assign misalign_next = (XM_MemWrite || XM_MemtoReg) && !aligned;

  // Read is taken before the edge, so a simultaneous store returns the old word.
  assign rd_word = mem_reg[word_idx];
  assign wb_next = XM_MemtoReg ? rd_word : ALUout;

  // Whole array must clear on reset, so it lives in flops rather than block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (store_ok) begin
      mem_reg[word_idx] <= XM_MD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MW_WBData   <= '0;
      MW_RD       <= '0;
      MW_RegWrite <= 1'b0;
      MW_Misalign <= 1'b0;
    end else begin
      MW_WBData   <= wb_next;
      MW_RD       <= XM_RD;
      MW_RegWrite <= XM_RegWrite && (XM_RD != 5'd0);
      MW_Misalign <= misalign_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MW_StoreCnt <= '0;
    end else if (store_ok && (MW_StoreCnt != 16'hFFFF)) begin
      MW_StoreCnt <= MW_StoreCnt + 16'd1;
    end
  end

endmodule
